// File: rtl/popcount_accum_if.sv
// Stream bundle for popcount_accum: config request, popcount word input and
// binarized result output. The slave modport is the accumulator's view.
interface popcount_accum_if #(
  parameter int BW_C   = 5,
  parameter int BW_LEN = 8,
  parameter int BW_ACC = 13
) ();
  logic              i_cfg_valid;
  logic              i_cfg_ready;
  logic [BW_LEN-1:0] i_cfg_len;
  logic [BW_ACC-1:0] i_cfg_thr;
  logic              i_valid;
  logic              i_ready;
  logic [BW_C-1:0]   i_cnt;
  logic              o_valid;
  logic              o_ready;
  logic [BW_ACC-1:0] o_sum;
  logic              o_bit;

  modport slave (
    input  i_cfg_valid, i_cfg_len, i_cfg_thr, i_valid, i_cnt, o_ready,
    output i_cfg_ready, i_ready, o_valid, o_sum, o_bit
  );

  modport master (
    output i_cfg_valid, i_cfg_len, i_cfg_thr, i_valid, i_cnt, o_ready,
    input  i_cfg_ready, i_ready, o_valid, o_sum, o_bit
  );
endinterface

// File: rtl/popcount_accum.sv
// Accumulates per-word popcounts over a configured word count and
// binarizes the total against a threshold. One registered result slot;
// the last word of a run stalls until that slot is free or draining.
module popcount_accum #(
  parameter int BW_C   = 5,
  parameter int BW_LEN = 8,
  parameter int BW_ACC = 13
) (
  input logic            clk,
  input logic            rst,
  popcount_accum_if.slave bus
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state_q, state_d;
  logic [BW_LEN-1:0] len_q, len_d;
  logic [BW_LEN-1:0] wcnt_q, wcnt_d;
  logic [BW_ACC-1:0] thr_q, thr_d;
  logic [BW_ACC-1:0] acc_q, acc_d;
  logic              ovalid_q, ovalid_d;
  logic [BW_ACC-1:0] osum_q, osum_d;
  logic              obit_q, obit_d;

  logic              last_w;
  logic              cfg_rdy;
  logic              in_rdy;
  logic              cfg_fire;
  logic              in_fire;
  logic              out_fire;
  logic [BW_ACC-1:0] sum_w;

  assign last_w   = (wcnt_q == (len_q - BW_LEN'(1)));
  assign cfg_rdy  = (state_q == IDLE);
  assign in_rdy   = (state_q == ACC) && (!last_w || !ovalid_q || bus.o_ready);
  assign cfg_fire = cfg_rdy && bus.i_cfg_valid;
  assign in_fire  = in_rdy && bus.i_valid;
  assign out_fire = ovalid_q && bus.o_ready;
  assign sum_w    = acc_q + BW_ACC'(bus.i_cnt);

  assign bus.i_cfg_ready = cfg_rdy;
  assign bus.i_ready     = in_rdy;
  assign bus.o_valid     = ovalid_q;
  assign bus.o_sum       = osum_q;
  assign bus.o_bit       = obit_q;

  // Next-state: config latch, accumulation, result load and output drain.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    thr_d    = thr_q;
    acc_d    = acc_q;
    osum_d   = osum_q;
    obit_d   = obit_q;
    ovalid_d = ovalid_q && !out_fire;
    unique case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          len_d   = (bus.i_cfg_len == '0) ? BW_LEN'(1) : bus.i_cfg_len;
          thr_d   = bus.i_cfg_thr;
          acc_d   = '0;
          wcnt_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_fire) begin
          if (!last_w) begin
            acc_d  = sum_w;
            wcnt_d = wcnt_q + BW_LEN'(1);
          end else begin
            // A load in the same cycle as an output transfer wins.
            osum_d   = sum_w;
            obit_d   = (sum_w >= thr_q);
            ovalid_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= BW_LEN'(1);
      wcnt_q   <= '0;
      thr_q    <= '0;
      acc_q    <= '0;
      ovalid_q <= 1'b0;
      osum_q   <= '0;
      obit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      thr_q    <= thr_d;
      acc_q    <= acc_d;
      ovalid_q <= ovalid_d;
      osum_q   <= osum_d;
      obit_q   <= obit_d;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Randomized and directed bench for popcount_accum with a sum/threshold
// reference model and an output scoreboard.
module tb_popcount_accum;
  localparam int BW_C   = 5;
  localparam int BW_LEN = 8;
  localparam int BW_ACC = 13;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_sum[$];
  int   exp_bit[$];

  popcount_accum_if #(.BW_C(BW_C), .BW_LEN(BW_LEN), .BW_ACC(BW_ACC)) bus ();

  popcount_accum #(.BW_C(BW_C), .BW_LEN(BW_LEN), .BW_ACC(BW_ACC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: a result transfers on the next rising edge when seen here.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.o_valid && bus.o_ready) begin
        if (exp_sum.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("o_sum", 32'(bus.o_sum), 32'(exp_sum.pop_front()));
          chk("o_bit", 32'(bus.o_bit), 32'(exp_bit.pop_front()));
        end
      end
    end
  end

  task automatic send_cfg(input int len, input int thr, input bit rnd);
    int n;
    @(negedge clk);
    if (rnd) bus.o_ready = 1'($urandom_range(0, 1));
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_len   = BW_LEN'(len);
    bus.i_cfg_thr   = BW_ACC'(thr);
    #1;
    n = 0;
    while (!bus.i_cfg_ready && n < 200) begin
      @(negedge clk);
      if (rnd) bus.o_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!bus.i_cfg_ready) chk("cfg_timeout", 1, 0);
    else @(posedge clk);
    #1;
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic send_word(input int cnt, input bit rnd);
    int n;
    @(negedge clk);
    if (rnd) bus.o_ready = 1'($urandom_range(0, 1));
    bus.i_valid = 1'b1;
    bus.i_cnt   = BW_C'(cnt);
    #1;
    n = 0;
    while (!bus.i_ready && n < 200) begin
      @(negedge clk);
      if (rnd) bus.o_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!bus.i_ready) chk("word_timeout", 1, 0);
    else @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Reference: one result per run, sum of words, bit = sum >= thr.
  task automatic run(input int len, input int thr, input int words[$], input bit rnd);
    int s;
    int n;
    n = (len == 0) ? 1 : len;
    s = 0;
    send_cfg(len, thr, rnd);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        s += words[i];
        exp_sum.push_back(s);
        exp_bit.push_back((s >= thr) ? 1 : 0);
      end else begin
        s += words[i];
      end
      send_word(words[i], rnd);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.o_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w[$];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_len   = '0;
    bus.i_cfg_thr   = '0;
    bus.i_valid     = 1'b0;
    bus.i_cnt       = '0;
    bus.o_ready     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 32'(bus.o_valid), 0);
    chk("rst_o_sum", 32'(bus.o_sum), 0);
    chk("rst_o_bit", 32'(bus.o_bit), 0);
    chk("rst_cfg_ready", 32'(bus.i_cfg_ready), 1);
    chk("rst_i_ready", 32'(bus.i_ready), 0);
    rst = 1'b0;

    // 1: basic run and output timing
    w = '{16, 0, 8, 7};
    run(4, 30, w, 1'b0);
    @(negedge clk);
    chk("t1_valid_rise", 32'(bus.o_valid), 1);
    chk("t1_sum", 32'(bus.o_sum), 31);
    chk("t1_bit", 32'(bus.o_bit), 1);
    @(negedge clk);
    chk("t1_valid_fall", 32'(bus.o_valid), 0);

    // 2: len 0 behaves as 1, equal meets threshold
    w = '{5};
    run(0, 5, w, 1'b0);
    @(negedge clk);
    #1;
    chk("t2_cfg_ready", 32'(bus.i_cfg_ready), 1);
    chk("t2_i_ready", 32'(bus.i_ready), 0);
    chk("t2_sum", 32'(bus.o_sum), 5);
    drain();

    // 3: back-pressure, stalled last word and same-cycle reload
    @(negedge clk);
    bus.o_ready = 1'b0;
    w = '{3, 4};
    run(2, 100, w, 1'b0);
    send_cfg(2, 1, 1'b0);
    send_word(1, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_cnt   = BW_C'(1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_ready", 32'(bus.i_ready), 0);
      chk("t3_hold_valid", 32'(bus.o_valid), 1);
      chk("t3_hold_sum", 32'(bus.o_sum), 7);
      @(negedge clk);
    end
    exp_sum.push_back(2);
    exp_bit.push_back(1);
    bus.o_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(bus.i_ready), 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    bus.o_ready = 1'b0;
    #1;
    chk("t3_valid_kept", 32'(bus.o_valid), 1);
    chk("t3_new_sum", 32'(bus.o_sum), 2);
    drain();

    // 4: maximum length and count, no wrap
    w = {};
    for (int i = 0; i < 255; i++) w.push_back(31);
    run(255, 8000, w, 1'b0);
    @(negedge clk);
    chk("t4_sum", 32'(bus.o_sum), 7905);
    chk("t4_bit", 32'(bus.o_bit), 0);
    drain();

    // 5: reset mid-run discards partial sum
    send_cfg(8, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(20, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_o_valid", 32'(bus.o_valid), 0);
    chk("t5_cfg_ready", 32'(bus.i_cfg_ready), 1);
    chk("t5_i_ready", 32'(bus.i_ready), 0);
    w = '{2};
    run(1, 3, w, 1'b0);
    @(negedge clk);
    chk("t5_sum", 32'(bus.o_sum), 2);
    chk("t5_bit", 32'(bus.o_bit), 0);
    drain();

    // 6: valid in IDLE is ignored
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_cnt   = BW_C'(25);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_idle_ready", 32'(bus.i_ready), 0);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    w = '{9};
    run(1, 10, w, 1'b0);
    @(negedge clk);
    chk("t6_sum", 32'(bus.o_sum), 9);
    chk("t6_bit", 32'(bus.o_bit), 0);
    drain();

    // Random runs with random back-pressure and gaps
    for (int r = 0; r < 40; r++) begin
      int len;
      int thr;
      int n;
      len = int'($urandom_range(0, 12));
      thr = int'($urandom_range(0, 300));
      n = (len == 0) ? 1 : len;
      w = {};
      for (int i = 0; i < n; i++) w.push_back(int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run(len, thr, w, 1'b1);
    end
    drain();
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_sum.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcount_accum.md
Name: popcount_accum

Overview:
Downstream consumer of the bit-count stage. It accumulates per-word popcounts over a configurable number of words to form one neuron's dot-product sum, then binarizes the sum against a threshold. Inputs arrive on a valid/ready stream from the popcount array. The result leaves on a registered valid/ready output toward the activation buffer.

Parameters:
BW_C, 5, width of incoming popcount word; must hold 2**BW_O for a 16-bit counted word.
BW_LEN, 8, width of word-count configuration.
BW_ACC, 13, accumulator and threshold width; must be at least BW_C+BW_LEN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
i_cfg_valid  input  1  configuration request.
i_cfg_ready  output  1  configuration accepted when high with i_cfg_valid.
i_cfg_len  input  BW_LEN  words per sum; 0 is treated as 1.
i_cfg_thr  input  BW_ACC  unsigned threshold.
i_valid  input  1  popcount word valid.
i_ready  output  1  popcount word accepted when high with i_valid.
i_cnt  input  BW_C  unsigned popcount of one word.
o_valid  output  1  result valid.
o_ready  input  1  downstream accepts result.
o_sum  output  BW_ACC  accumulated sum.
o_bit  output  1  binarized activation: 1 when o_sum >= threshold.

Behaviour:
- Handshake: a transfer occurs on a cycle where valid and ready are both high. Once raised, valid holds and data stays stable until the transfer. Ready may depend combinationally on state and o_ready only, never on the valid inputs.
- FSM states:
  - IDLE: i_cfg_ready=1, i_ready=0. A cfg transfer latches len (0 becomes 1) and thr, clears acc and word counter wcnt, and moves to ACC.
  - ACC: i_cfg_ready=0. i_ready=1 while wcnt < len-1. On the last word (wcnt == len-1), i_ready = !o_valid || o_ready.
- Non-last word transfer: acc <= acc + i_cnt; wcnt <= wcnt + 1.
- Last word transfer: o_sum <= acc + i_cnt; o_bit <= (acc + i_cnt) >= thr (unsigned); o_valid <= 1; return to IDLE.
- Latency: o_valid rises the cycle after the last input transfer.
- Output register: o_valid clears on an output transfer unless a new result loads in the same cycle. A same-cycle load takes priority and holds o_valid high with the new data.
- Overlap: a new config is accepted in IDLE while a previous result is still pending. Its input words stream until its own last word, which stalls until the output slot frees.
- Arithmetic: unsigned throughout, no saturation. Widths guarantee no overflow for i_cnt <= 2**BW_C-1 and len <= 2**BW_LEN-1. No range check is made on i_cnt.
- Reset values: state=IDLE, acc=0, wcnt=0, o_valid=0, o_sum=0, o_bit=0. Hence i_cfg_ready=1 and i_ready=0 during and after reset.
- Reset mid-operation: the partial sum and any pending result are discarded, and no output is produced for the interrupted config.
- Inputs presented while i_ready=0 are ignored and not consumed.

Test Plan:
1. cfg len=4, thr=30; feed i_cnt 16,0,8,7 with back-to-back valid and o_ready=1 -> one cycle after the 4th transfer: o_valid=1, o_sum=31, o_bit=1, then o_valid=0 next cycle.
2. cfg len=0, thr=5; feed i_cnt 5 -> o_sum=5, o_bit=1 (equal meets threshold); the block consumes exactly one word and returns to IDLE.
3. Back-pressure: o_ready=0. First run len=2 (3,4) gives o_sum=7. Second run len=2 (1,1): the second word sees i_ready=0 until o_ready rises. On o_ready pulse -> 7 transfers, 2 loads the next cycle, and o_valid stays high continuously.
4. Max width: len=255, every i_cnt=31, thr=8000 -> o_sum=7905, o_bit=0, with no wrap.
5. Reset mid-run: len=8, after 3 words assert rst for 1 cycle -> o_valid=0, i_cfg_ready=1, i_ready=0. A new len=1 run with i_cnt=2 then gives o_sum=2, with no residue from the interrupted run.
6. Idle valid: i_valid=1 in IDLE with no cfg -> i_ready=0, nothing accumulated; a subsequent len=1, i_cnt=9 gives o_sum=9.
